// File: rtl/counter28_pkg.sv
// Shared types and defaults for the counter28 timing core.
package counter28_pkg;

  localparam int CNT_W_DEFAULT   = 28;
  localparam int PRESC_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/counter28_prescaler.sv
// Tick divider: counts 0..presc_div_i while enabled and pulses tick_o on the last count.
module counter28_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic               sclr_i,
  input  logic [PRESC_W-1:0] presc_div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == presc_div_i);

  always_comb begin
    cnt_d = cnt_q + PRESC_W'(1);
    if (!en_i || sclr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/counter28_core.sv
// Prescaled up/down counter with terminal value, wrap/one-shot, sticky flag and irq pulse.
// COUNTER28_PRESCALER_EN builds the prescaler; otherwise every RUN cycle is a tick.
//   state   | meaning
//   ST_IDLE | not counting
//   ST_RUN  | counting on prescaler ticks
//   ST_DONE | one-shot finished, count held
module counter28_core
  import counter28_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int PRESC_W = PRESC_W_DEFAULT
) (
  input  logic               s00_axi_aclk,
  input  logic               s00_axi_aresetn,
  input  logic               ctrl_en,
  input  logic               ctrl_dir,
  input  logic               ctrl_mode,
  input  logic               load_pulse,
  input  logic [CNT_W-1:0]   load_value,
  input  logic               clr_pulse,
  input  logic [CNT_W-1:0]   limit,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               sts_clr,
  output logic [CNT_W-1:0]   count,
  output logic               tc_flag,
  output logic               running,
  output logic               irq
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             irq_q;
  logic             run_q;
  logic             in_run, strobe, tick, term_hit;

  assign in_run = (state_q == ST_RUN);
  assign strobe = clr_pulse | load_pulse;

`ifdef COUNTER28_PRESCALER_EN
  logic presc_tick;

  counter28_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i       (s00_axi_aclk),
    .rst_n_i     (s00_axi_aresetn),
    .en_i        (in_run),
    .sclr_i      (strobe),
    .presc_div_i (presc_div),
    .tick_o      (presc_tick)
  );

  assign tick = in_run & presc_tick & ~strobe;
`else
  logic unused_presc;

  assign unused_presc = ^presc_div;
  assign tick         = in_run & ~strobe;
`endif

  // A strobe overrides the tick, so it also suppresses the terminal event.
  always_comb begin
    term_hit = tick & ((ctrl_dir == DIR_DOWN) ? (count_q == '0) : (count_q == limit));

    count_d = count_q;
    if (clr_pulse)       count_d = '0;
    else if (load_pulse) count_d = load_value;
    else if (term_hit) begin
      if (ctrl_mode == MODE_WRAP) count_d = (ctrl_dir == DIR_DOWN) ? limit : '0;
    end
    else if (tick)       count_d = (ctrl_dir == DIR_DOWN) ? count_q - CNT_W'(1)
                                                          : count_q + CNT_W'(1);

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ctrl_en) state_d = ST_RUN;
      ST_RUN: begin
        if (!ctrl_en)                                    state_d = ST_IDLE;
        else if (term_hit && ctrl_mode == MODE_ONESHOT)  state_d = ST_DONE;
      end
      ST_DONE: if (!ctrl_en || strobe) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    tc_d = term_hit ? 1'b1 : (sts_clr ? 1'b0 : tc_q);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      irq_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      irq_q   <= term_hit;
      run_q   <= (state_d == ST_RUN);
    end
  end

  assign count   = count_q;
  assign tc_flag = tc_q;
  assign running = run_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_counter28_core.sv
// Self-checking bench for counter28_core: behavioural model plus directed literal checks and random runs.
module tb_counter28_core;

  localparam int CNT_W   = 28;
  localparam int PRESC_W = 16;
  localparam longint MOD = 64'd1 << 28;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic clk = 1'b0, rst_n = 1'b1;
  logic en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0, clr = 1'b0, sts_clr = 1'b0;
  logic [CNT_W-1:0]   load_value = '0, limit = '0;
  logic [PRESC_W-1:0] presc_div = '0;
  logic [CNT_W-1:0]   count;
  logic               tc_flag, running, irq;

  int n_chk = 0, n_fail = 0, n_irq = 0;
  bit cmp_en = 1'b0;

  counter28_core #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .ctrl_en         (en),
    .ctrl_dir        (dir),
    .ctrl_mode       (mode),
    .load_pulse      (load),
    .load_value      (load_value),
    .clr_pulse       (clr),
    .limit           (limit),
    .presc_div       (presc_div),
    .sts_clr         (sts_clr),
    .count           (count),
    .tc_flag         (tc_flag),
    .running         (running),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: spec-level state, a run-cycle phase counter, modular count arithmetic.
  int               m_state = M_IDLE, m_phase = 0, m_next = M_IDLE;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_tc = 1'b0, m_irq = 1'b0, m_running = 1'b0;
  bit               m_hit, m_tick, m_term;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE; m_phase = 0; m_cnt = '0;
      m_tc = 1'b0; m_irq = 1'b0; m_running = 1'b0;
    end else begin
`ifdef COUNTER28_PRESCALER_EN
      m_hit = (m_phase % (int'(presc_div) + 1)) == int'(presc_div);
`else
      m_hit = 1'b1;
`endif
      m_tick = (m_state == M_RUN) && m_hit && !clr && !load;
      m_term = m_tick && (dir ? (m_cnt == 0) : (m_cnt == limit));
      if (m_state != M_RUN || clr || load) m_phase = 0;
      else m_phase++;

      if (clr) m_cnt = '0;
      else if (load) m_cnt = load_value;
      else if (m_term) begin
        if (!mode) m_cnt = dir ? limit : '0;
      end
      else if (m_tick)
        m_cnt = CNT_W'((dir ? longint'(m_cnt) + MOD - 1 : longint'(m_cnt) + 1) % MOD);

      case (m_state)
        M_IDLE:  m_next = en ? M_RUN : M_IDLE;
        M_RUN:   m_next = !en ? M_IDLE : ((m_term && mode) ? M_DONE : M_RUN);
        default: m_next = (!en || clr || load) ? M_IDLE : M_DONE;
      endcase
      m_state   = m_next;
      m_tc      = m_term ? 1'b1 : (sts_clr ? 1'b0 : m_tc);
      m_irq     = m_term;
      m_running = (m_state == M_RUN);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_count",   count,   m_cnt);
      chk("model_tc_flag", tc_flag, m_tc);
      chk("model_running", running, m_running);
      chk("model_irq",     irq,     m_irq);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    {en, dir, mode, load, clr, sts_clr} = '0;
    load_value = '0;
    limit      = '0;
    rst_n      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [CNT_W-1:0] wrap_cnt [6] = '{28'd0, 28'd1, 28'd2, 28'd3, 28'd0, 28'd1};
  logic             wrap_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [CNT_W-1:0] os_cnt   [8] = '{28'd5, 28'd4, 28'd3, 28'd2, 28'd1, 28'd0, 28'd0, 28'd0};
  logic             os_run   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic             os_irq   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef COUNTER28_PRESCALER_EN
  logic [CNT_W-1:0] ps_cnt   [9] = '{28'd0, 28'd0, 28'd0, 28'd0, 28'd1, 28'd1, 28'd1, 28'd1, 28'd2};
`else
  logic [CNT_W-1:0] ps_cnt   [9] = '{28'd0, 28'd1, 28'd2, 28'd3, 28'd4, 28'd5, 28'd6, 28'd7, 28'd8};
`endif
  logic [CNT_W-1:0] ro_cnt   [6] = '{28'hFFFFFFE, 28'hFFFFFFF, 28'd0, 28'd1, 28'd2, 28'd0};
  logic             ro_irq   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    presc_div = '0;
    do_reset();
    cmp_en = 1'b1;
    chk("reset_count",   count,   0);
    chk("reset_tc_flag", tc_flag, 0);
    chk("reset_running", running, 0);
    chk("reset_irq",     irq,     0);

    // wrap up to limit 3
    limit = 28'd3;
    en    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wrap_count", count, wrap_cnt[i]);
      chk("wrap_irq",   irq,   wrap_irq[i]);
    end
    chk("wrap_tc_flag", tc_flag, 1);

    // one-shot down from 5
    do_reset();
    load_value = 28'd5; load = 1'b1; mode = 1'b1; dir = 1'b1; en = 1'b1;
    n_irq = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("oneshot_count",   count,   os_cnt[i]);
      chk("oneshot_running", running, os_run[i]);
      chk("oneshot_irq",     irq,     os_irq[i]);
      n_irq += int'(irq);
      load = 1'b0;
    end
    chk("oneshot_irq_total", n_irq, 1);
    clr = 1'b1;
    @(negedge clk);
    chk("done_clr_idle", running, 0);
    clr = 1'b0;
    @(negedge clk);
    chk("done_rerun", running, 1);

    // prescaler divisor 3
    presc_div = 16'd3;
    do_reset();
    limit = 28'd100;
    en    = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("presc_count", count, ps_cnt[i]);
    end

    // strobe priority and set-over-clear
    presc_div = '0;
    do_reset();
    limit = 28'd100;
    en    = 1'b1;
    repeat (5) @(negedge clk);
    chk("prio_pre_count", count, 4);
    clr = 1'b1; load = 1'b1; load_value = 28'h0ABCDEF;
    @(negedge clk);
    chk("prio_clr_wins", count, 0);
    clr = 1'b0; load = 1'b0; limit = 28'd3;
    repeat (3) @(negedge clk);
    chk("prio_at_limit", count, 3);
    sts_clr = 1'b1;
    @(negedge clk);
    chk("set_beats_clr_tc",  tc_flag, 1);
    chk("set_beats_clr_irq", irq,     1);
    @(negedge clk);
    chk("sts_clr_clears", tc_flag, 0);
    sts_clr = 1'b0;

    // rollover through 2^28-1
    do_reset();
    limit = 28'd2; load_value = 28'hFFFFFFE; load = 1'b1; en = 1'b1;
    n_irq = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("roll_count", count, ro_cnt[i]);
      chk("roll_irq",   irq,   ro_irq[i]);
      n_irq += int'(irq);
      load = 1'b0;
    end
    chk("roll_irq_total", n_irq, 1);

    // asynchronous reset mid-run
    do_reset();
    limit = 28'hFFFFFFF; load_value = 28'h123; load = 1'b1; en = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("mid_pre_count", count, 28'h123);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count",   count,   0);
    chk("mid_rst_tc_flag", tc_flag, 0);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_irq",     irq,     0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized segments
    for (int s = 0; s < 6; s++) begin
      presc_div = PRESC_W'($urandom_range(0, 3));
      do_reset();
      limit = CNT_W'($urandom_range(0, 12));
      dir   = 1'($urandom_range(0, 1));
      mode  = 1'($urandom_range(0, 1));
      en    = 1'b1;
      repeat (250) begin
        @(negedge clk);
        en      = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 15) == 0) dir  = ~dir;
        if ($urandom_range(0, 15) == 0) mode = ~mode;
        if ($urandom_range(0, 29) == 0) limit = CNT_W'($urandom_range(0, 12));
        load    = ($urandom_range(0, 24) == 0);
        load_value = ($urandom_range(0, 3) == 0) ? CNT_W'(28'hFFFFFF0 + $urandom_range(0, 15))
                                                 : CNT_W'($urandom_range(0, 15));
        clr     = ($urandom_range(0, 39) == 0);
        sts_clr = ($urandom_range(0, 7) == 0);
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/counter28_core.md
# counter28_core

Timing core of the counter28 IP. It sits directly downstream of the AXI4-Lite register file and consumes its control fields and write strobes. It produces the 28-bit count and status that the register file returns on reads. It implements a prescaled up/down counter with a programmable terminal value, wrap or one-shot mode, a sticky terminal flag and a single-cycle interrupt pulse.

## Interface
Parameters:
- CNT_W, 28, counter width
- PRESC_W, 16, prescaler width

Ports:
- s00_axi_aclk  in  1  clock, shared with the AXI4-Lite slave
- s00_axi_aresetn  in  1  asynchronous, active-low reset
- ctrl_en  in  1  run enable (level)
- ctrl_dir  in  1  0 = count up, 1 = count down
- ctrl_mode  in  1  0 = wrap, 1 = one-shot
- load_pulse  in  1  one-cycle strobe: count <= load_value
- load_value  in  CNT_W  value to load
- clr_pulse  in  1  one-cycle strobe: count <= 0
- limit  in  CNT_W  terminal value
- presc_div  in  PRESC_W  prescaler divisor minus 1
- sts_clr  in  1  one-cycle write-1-to-clear strobe for tc_flag
- count  out  CNT_W  current count
- tc_flag  out  1  sticky terminal-count flag
- running  out  1  high while the FSM is in RUN
- irq  out  1  one-cycle pulse on each terminal event

## Operation
- FSM states:
  - IDLE: not counting.
  - RUN: counting.
  - DONE: one-shot finished; count is held.
- Transitions:
  - IDLE -> RUN when ctrl_en = 1.
  - RUN -> IDLE when ctrl_en = 0.
  - RUN -> DONE on a terminal event when ctrl_mode = 1.
  - DONE -> IDLE when ctrl_en = 0, on clr_pulse, or on load_pulse. If ctrl_en is still 1, the FSM re-enters RUN on the next cycle.
- Count update priority, per cycle: clr_pulse > load_pulse > tick. Both strobes act in any state.
- A tick occurs only in RUN, from the prescaler.
- Terminal event (on a tick only):
  - Up: count == limit. Count goes to 0 in wrap mode; it holds in one-shot mode.
  - Down: count == 0. Count goes to limit in wrap mode; it holds in one-shot mode.
- A tick that is not a terminal event increments or decrements count modulo 2^CNT_W.
- Terminal detection uses equality only. If limit is set below count while counting up, count rolls over at 2^28−1 to 0 with no flag, then reaches limit normally.
- limit, ctrl_dir and ctrl_mode are sampled live every cycle.
- On a terminal event: tc_flag <= 1 and irq = 1 for exactly one cycle. If set and sts_clr coincide, set wins.

## Timing
- Reset values: count = 0, tc_flag = 0, running = 0, irq = 0, FSM = IDLE, prescaler = 0.
- All outputs are registered.
- count, tc_flag and irq update on the clock edge that consumes the tick or strobe. irq coincides with the new count value.
- With presc_div = 0, a tick occurs on every RUN cycle. The first count change is 2 cycles after ctrl_en rises: 1 cycle to enter RUN, then the tick.
- The prescaler counts 0..presc_div and ticks when it equals presc_div, then returns to 0. Tick period = presc_div + 1 cycles.
- The prescaler resets to 0 on clr_pulse, on load_pulse, and whenever the FSM is not in RUN.
- Reset asserted mid-operation clears everything immediately, asynchronously. Deassertion is synchronised externally.

## Configuration
- COUNTER28_PRESCALER_EN:
  - Defined: prescaler present and behaves as above.
  - Undefined: the prescaler is not built, every RUN cycle is a tick, and presc_div is ignored (the port remains for a stable interface).

## Structure
- Package counter28_pkg holds:
  - CNT_W and PRESC_W defaults.
  - The FSM state enum: ST_IDLE, ST_RUN, ST_DONE.
  - Direction and mode constants: DIR_UP/DIR_DOWN, MODE_WRAP/MODE_ONESHOT.
- Sub-module counter28_prescaler takes enable/sync-clear/presc_div and outputs tick. It is instantiated only under COUNTER28_PRESCALER_EN.

## Test plan
- Wrap up: presc_div = 0, limit = 3, en = 1, up. Required: count 0,1,2,3,0,1. irq pulses once per wrap, in the cycle count becomes 0. tc_flag = 1.
- One-shot down: load_value = 5, load_pulse, mode = 1, dir = 1, en = 1. Required: count 5→0 in 5 ticks, then DONE; count holds 0, running = 0, one irq. A clr_pulse then returns the FSM to IDLE, and it re-enters RUN while en = 1.
- Prescaler: presc_div = 3, limit = 100. Required: count increments every 4 cycles. With the macro undefined, it increments every cycle.
- Priority: clr_pulse and load_pulse (value 0x0ABCDEF) asserted together mid-run. Required: count = 0. sts_clr in the same cycle as a terminal event leaves tc_flag = 1.
- Rollover: load 0xFFFFFFE, limit = 2, up, wrap. Required: count FFFFFFE, FFFFFFF, 0, 1, 2, then wrap to 0. Exactly one irq, at the 2→0 event.
- Reset mid-run: deassert s00_axi_aresetn with count = 0x123. Required: all outputs 0 immediately, FSM in IDLE.
